// File: rtl/sim_checker.sv
// sim_checker: releases a core from reset, watches its store bus and
// checks stores in order against a programmed table of expected stores.
// Ports: clk; reset (async, active-low); cfg_we/cfg_idx/cfg_addr/cfg_data
//   table write port; start pulse and exp_count (entries to check);
//   mem_write/data_adr/write_data monitored store bus; core_reset to the
//   core; done/pass/timeout verdict; err_cnt/match_cnt/cycle_cnt stats.
module sim_checker #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 8,
    parameter int RST_CYCLES  = 1,
    parameter int TIMEOUT     = 30,
    parameter int STOP_ON_ERR = 1,
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IW-1:0]     cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              start,
    input  logic [IW:0]       exp_count,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] data_adr,
    input  logic [DATA_W-1:0] write_data,
    output logic              core_reset,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [7:0]        err_cnt,
    output logic [IW:0]       match_cnt,
    output logic [15:0]       cycle_cnt
);

    typedef enum logic [2:0] {
        sIdle,
        sRst,
        sRun,
        sPass,
        sFail
    } stateT;

    localparam logic [IW:0] DEPTH_C  = (IW+1)'(DEPTH);
    localparam logic [15:0] RST_LAST =
        (RST_CYCLES > 1) ? 16'(RST_CYCLES - 1) : 16'd0;
    // The run gives up once the cycle count would reach this value.
    localparam logic [15:0] TMO_AT   =
        (TIMEOUT > 1) ? 16'(TIMEOUT - 1) : 16'd0;

    // Expected-store table; deliberately not reset so that a
    // run can be repeated after a reset without reprogramming.
    logic [ADDR_W-1:0] expAddr [DEPTH];
    logic [DATA_W-1:0] expData [DEPTH];

    stateT       state, stateN;
    logic [IW:0] expCnt, expCntN;
    logic [IW:0] ptr, ptrN;
    logic [7:0]  errCnt, errN;
    logic [IW:0] matchCnt, matchN;
    logic [15:0] cycleCnt, cycN;
    logic [15:0] rstCnt, rstCntN;
    logic        tmoQ, tmoN;
    logic        coreResetQ;
    logic        doneQ;
    logic        passQ;

    logic          cfgOpen;
    logic [IW-1:0] ptrIdx;
    logic          hitAddr;
    logic          hitData;
    logic          isMatch;
    logic          isMiss;
    logic          stopMiss;

    assign cfgOpen = (state == sIdle) || (state == sPass) ||
                     (state == sFail);
    assign ptrIdx  = ptr[IW-1:0];
    assign hitAddr = mem_write && (data_adr == expAddr[ptrIdx]);
    assign hitData = (write_data == expData[ptrIdx]);
    assign isMatch = hitAddr && hitData;
    assign isMiss  = hitAddr && !hitData;
    assign stopMiss = isMiss && (STOP_ON_ERR != 0);

    // Table write port, open only while no run is in progress.
    always_ff @(posedge clk) begin
        if (cfg_we && cfgOpen && ({1'b0, cfg_idx} < DEPTH_C)) begin
            expAddr[cfg_idx] <= cfg_addr;
            expData[cfg_idx] <= cfg_data;
        end
    end

    always_comb begin
        stateN  = state;
        expCntN = expCnt;
        ptrN    = ptr;
        errN    = errCnt;
        matchN  = matchCnt;
        cycN    = cycleCnt;
        rstCntN = rstCnt;
        tmoN    = tmoQ;
        unique case (state)
            sIdle, sPass, sFail: begin
                if (start) begin
                    stateN  = sRst;
                    // Never check past the end of the table.
                    expCntN = (exp_count > DEPTH_C) ? DEPTH_C : exp_count;
                    ptrN    = '0;
                    errN    = '0;
                    matchN  = '0;
                    cycN    = '0;
                    rstCntN = '0;
                    tmoN    = 1'b0;
                end
            end
            sRst: begin
                if (rstCnt == RST_LAST) begin
                    stateN = sRun;
                end else begin
                    rstCntN = rstCnt + 16'd1;
                end
            end
            sRun: begin
                if (cycleCnt != 16'hFFFF) begin
                    cycN = cycleCnt + 16'd1;
                end
                if (isMatch) begin
                    ptrN   = ptr + 1'b1;
                    matchN = matchCnt + 1'b1;
                end
                if (isMiss) begin
                    if (errCnt != 8'hFF) begin
                        errN = errCnt + 8'd1;
                    end
                    if (STOP_ON_ERR == 0) begin
                        ptrN = ptr + 1'b1;
                    end
                end
                // Completion is judged on the updated pointer so the
                // verdict lands one edge after the deciding store, and
                // it outranks a timeout on the same cycle.
                if (stopMiss) begin
                    stateN = sFail;
                end else if (ptrN == expCnt) begin
                    stateN = (errN == 8'd0) ? sPass : sFail;
                end else if (cycN >= TMO_AT) begin
                    stateN = sFail;
                    tmoN   = 1'b1;
                end
            end
            default: begin
                stateN = sIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= sIdle;
            expCnt     <= '0;
            ptr        <= '0;
            errCnt     <= '0;
            matchCnt   <= '0;
            cycleCnt   <= '0;
            rstCnt     <= '0;
            tmoQ       <= 1'b0;
            coreResetQ <= 1'b1;
            doneQ      <= 1'b0;
            passQ      <= 1'b0;
        end else begin
            state      <= stateN;
            expCnt     <= expCntN;
            ptr        <= ptrN;
            errCnt     <= errN;
            matchCnt   <= matchN;
            cycleCnt   <= cycN;
            rstCnt     <= rstCntN;
            tmoQ       <= tmoN;
            coreResetQ <= (stateN != sRun);
            doneQ      <= (stateN == sPass) || (stateN == sFail);
            passQ      <= (stateN == sPass);
        end
    end

    assign core_reset = coreResetQ;
    assign done       = doneQ;
    assign pass       = passQ;
    assign timeout    = tmoQ;
    assign err_cnt    = errCnt;
    assign match_cnt  = matchCnt;
    assign cycle_cnt  = cycleCnt;

endmodule

// File: tb/tb_sim_checker.sv
// tb_sim_checker: runs a stop-on-error and a continue-on-error checker
// side by side against a behavioural model of the run rules.
module tb_sim_checker;

    localparam int PH_IDLE = 0;
    localparam int PH_RST  = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_PASS = 3;
    localparam int PH_FAIL = 4;
    localparam int TMO     = 30;
    localparam int RSTC    = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_idx = '0;
    logic [31:0] cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic        start = 1'b0;
    logic [3:0]  exp_count = '0;
    logic        mem_write = 1'b0;
    logic [31:0] data_adr = '0;
    logic [31:0] write_data = '0;

    logic        coreRst [2];
    logic        doneO [2];
    logic        passO [2];
    logic        tmoO [2];
    logic [7:0]  errO [2];
    logic [3:0]  matchO [2];
    logic [15:0] cycO [2];

    int checks = 0;
    int failures = 0;
    bit chkEn = 1'b0;

    sim_checker #(.STOP_ON_ERR(1)) dutS (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .exp_count(exp_count),
        .mem_write(mem_write), .data_adr(data_adr),
        .write_data(write_data),
        .core_reset(coreRst[0]), .done(doneO[0]), .pass(passO[0]),
        .timeout(tmoO[0]), .err_cnt(errO[0]),
        .match_cnt(matchO[0]), .cycle_cnt(cycO[0])
    );

    sim_checker #(.STOP_ON_ERR(0)) dutC (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .exp_count(exp_count),
        .mem_write(mem_write), .data_adr(data_adr),
        .write_data(write_data),
        .core_reset(coreRst[1]), .done(doneO[1]), .pass(passO[1]),
        .timeout(tmoO[1]), .err_cnt(errO[1]),
        .match_cnt(matchO[1]), .cycle_cnt(cycO[1])
    );

    always #5 clk = ~clk;

    // Model state, index 0 = stop-on-error, 1 = continue.
    int          mPh [2];
    int          mRst [2];
    int          mCnt [2];
    int          mPtr [2];
    int          mErr [2];
    int          mMat [2];
    int          mCyc [2];
    bit          mTmo [2];
    logic [31:0] mA [2][8];
    logic [31:0] mD [2][8];

    task automatic chk(string nm, int m, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %0d expected %0d t=%0t",
                     nm, m, act, exp, $time);
        end
    endtask

    task automatic modelClear(int m);
        mPh[m] = PH_IDLE; mPtr[m] = 0; mErr[m] = 0;
        mMat[m] = 0; mCyc[m] = 0; mTmo[m] = 1'b0; mCnt[m] = 0;
    endtask

    task automatic modelStep(int m);
        bit stopMode;
        bit failNow;
        stopMode = (m == 0);
        failNow = 1'b0;
        if (mPh[m] == PH_IDLE || mPh[m] >= PH_PASS) begin
            if (cfg_we) begin
                mA[m][cfg_idx] = cfg_addr;
                mD[m][cfg_idx] = cfg_data;
            end
            if (start) begin
                mPh[m] = PH_RST;
                mCnt[m] = (exp_count > 8) ? 8 : int'(exp_count);
                mPtr[m] = 0; mErr[m] = 0; mMat[m] = 0;
                mCyc[m] = 0; mTmo[m] = 1'b0; mRst[m] = RSTC;
            end
        end else if (mPh[m] == PH_RST) begin
            mRst[m]--;
            if (mRst[m] <= 0) mPh[m] = PH_RUN;
        end else begin
            if (mCyc[m] < 65535) mCyc[m]++;
            if (mem_write && data_adr == mA[m][mPtr[m] % 8]) begin
                if (write_data == mD[m][mPtr[m] % 8]) begin
                    mPtr[m]++;
                    mMat[m]++;
                end else begin
                    if (mErr[m] < 255) mErr[m]++;
                    if (stopMode) failNow = 1'b1;
                    else mPtr[m]++;
                end
            end
            if (failNow) mPh[m] = PH_FAIL;
            else if (mPtr[m] == mCnt[m])
                mPh[m] = (mErr[m] == 0) ? PH_PASS : PH_FAIL;
            else if (mCyc[m] >= TMO - 1) begin
                mPh[m] = PH_FAIL;
                mTmo[m] = 1'b1;
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int m = 0; m < 2; m++) modelClear(m);
        end else begin
            for (int m = 0; m < 2; m++) modelStep(m);
        end
    end

    always @(negedge clk) begin
        if (chkEn) begin
            for (int m = 0; m < 2; m++) begin
                chk("core_reset", m, coreRst[m], mPh[m] != PH_RUN);
                chk("done", m, doneO[m], mPh[m] >= PH_PASS);
                if (mPh[m] >= PH_PASS)
                    chk("pass", m, passO[m], mPh[m] == PH_PASS);
                chk("timeout", m, tmoO[m], mTmo[m]);
                chk("err_cnt", m, errO[m], mErr[m]);
                chk("match_cnt", m, matchO[m], mMat[m]);
                chk("cycle_cnt", m, cycO[m], mCyc[m]);
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic writeEntry(int idx, logic [31:0] a, logic [31:0] d);
        cfg_we = 1'b1;
        cfg_idx = 3'(idx);
        cfg_addr = a;
        cfg_data = d;
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic startRun(int cnt);
        exp_count = 4'(cnt);
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic runTo(int k);
        repeat (k + 1) cyc();
    endtask

    task automatic store(logic [31:0] a, logic [31:0] d);
        mem_write = 1'b1;
        data_adr = a;
        write_data = d;
        cyc();
        mem_write = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        chkEn = 1'b1;
        cyc();
        chk("rst_core_reset", 0, coreRst[0], 1);
        chk("rst_done", 0, doneO[0], 0);
        chk("rst_err", 1, errO[1], 0);
        chk("rst_cycle", 1, cycO[1], 0);
        reset = 1'b1;
        cyc();
        for (int i = 0; i < 8; i++)
            writeEntry(i, 32'h200 + 32'(4 * i), 32'(i));

        writeEntry(0, 32'h64, 32'h19);
        startRun(1);
        runTo(17);
        store(32'h64, 32'h19);
        chk("r45_done", 0, doneO[0], 1);
        chk("r45_pass", 0, passO[0], 1);
        chk("r45_match", 0, matchO[0], 1);
        chk("r45_cycle", 0, cycO[0], 18);

        startRun(1);
        runTo(2);
        store(32'h64, 32'h07);
        chk("r46_done", 0, doneO[0], 1);
        chk("r46_pass", 0, passO[0], 0);
        chk("r46_err", 0, errO[0], 1);
        chk("r46_tmo", 0, tmoO[0], 0);
        chk("r46_core_reset", 0, coreRst[0], 1);

        writeEntry(0, 32'h100, 32'hA);
        writeEntry(1, 32'h104, 32'hB);
        writeEntry(2, 32'h108, 32'hC);
        startRun(3);
        runTo(1);
        store(32'h100, 32'hA);
        cyc();
        store(32'h104, 32'hBAD);
        cyc();
        chk("r47_running", 1, doneO[1], 0);
        store(32'h108, 32'hC);
        chk("r47_done", 1, doneO[1], 1);
        chk("r47_pass", 1, passO[1], 0);
        chk("r47_err", 1, errO[1], 1);
        chk("r47_match", 1, matchO[1], 2);

        startRun(3);
        repeat (30) cyc();
        chk("r48_done", 0, doneO[0], 1);
        chk("r48_tmo", 0, tmoO[0], 1);
        chk("r48_cycle", 0, cycO[0], 29);
        chk("r48_tmo", 1, tmoO[1], 1);

        writeEntry(0, 32'h64, 32'h19);
        startRun(1);
        runTo(10);
        chk("r49_precycle", 0, cycO[0], 10);
        reset = 1'b0;
        #1;
        chk("r49_core_reset", 0, coreRst[0], 1);
        chk("r49_cycle", 0, cycO[0], 0);
        chk("r49_done", 1, doneO[1], 0);
        cyc();
        reset = 1'b1;
        cyc();
        startRun(1);
        runTo(5);
        store(32'h64, 32'h19);
        chk("r49_pass", 0, passO[0], 1);
        chk("r49_rerun_cycle", 1, cycO[1], 6);

        startRun(0);
        repeat (2) cyc();
        chk("r50_pass", 0, passO[0], 1);
        chk("r50_cycle", 0, cycO[0], 1);

        startRun(1);
        runTo(3);
        writeEntry(0, 32'h64, 32'h55);
        store(32'h64, 32'h19);
        chk("r50_cfg_ignored", 0, passO[0], 1);
        chk("r50_cfg_match", 1, matchO[1], 1);

        for (int r = 0; r < 40; r++) begin
            int n;
            bit fin;
            n = $urandom_range(0, 3);
            for (int w = 0; w < n; w++)
                writeEntry($urandom_range(0, 7),
                           32'h10 + 32'(4 * $urandom_range(0, 3)),
                           32'($urandom_range(0, 3)));
            startRun($urandom_range(0, 8));
            fin = 1'b0;
            for (int c = 0; c < 45 && !fin; c++) begin
                mem_write = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 1) == 1) begin
                    int j;
                    j = mPtr[1] % 8;
                    data_adr = mA[1][j];
                    write_data = ($urandom_range(0, 5) == 0) ?
                                 (mD[1][j] ^ 32'h1) : mD[1][j];
                end else begin
                    data_adr = 32'h10 + 32'(4 * $urandom_range(0, 3));
                    write_data = 32'($urandom_range(0, 3));
                end
                cfg_we = ($urandom_range(0, 7) == 0);
                cfg_idx = 3'($urandom_range(0, 7));
                cfg_addr = 32'h10 + 32'(4 * $urandom_range(0, 3));
                cfg_data = 32'($urandom_range(0, 3));
                exp_count = 4'($urandom_range(0, 15));
                start = ($urandom_range(0, 15) == 0) &&
                        (mPh[0] == PH_RST || mPh[0] == PH_RUN) &&
                        (mPh[1] == PH_RST || mPh[1] == PH_RUN);
                cyc();
                fin = (mPh[0] >= PH_PASS) && (mPh[1] >= PH_PASS);
            end
            mem_write = 1'b0;
            cfg_we = 1'b0;
            start = 1'b0;
            chk("run_finished", r, fin, 1);
        end

        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sim_checker.md
SIM_CHECKER -- requirements
Module: sim_checker

Interface
REQ-001 Parameter ADDR_W, default 32, width of the monitored address bus.
REQ-002 Parameter DATA_W, default 32, width of the monitored write-data bus.
REQ-003 Parameter DEPTH, default 8, number of expected-store table entries; IW = clog2(DEPTH).
REQ-004 Parameter RST_CYCLES, default 1, number of cycles core_reset is held after start.
REQ-005 Parameter TIMEOUT, default 30, maximum number of RUN cycles before failure.
REQ-006 Parameter STOP_ON_ERR, default 1; 1 ends the test on the first mismatch, 0 records the mismatch and continues.
REQ-007 clk  in  1  sole clock; all state changes on its rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 cfg_we  in  1  table write strobe.
REQ-010 cfg_idx  in  IW  table entry index.
REQ-011 cfg_addr  in  ADDR_W  expected store address.
REQ-012 cfg_data  in  DATA_W  expected store data.
REQ-013 start  in  1  one-cycle pulse that launches a test run.
REQ-014 exp_count  in  IW+1  number of valid table entries, sampled on start.
REQ-015 mem_write  in  1  DUT store strobe.
REQ-016 data_adr  in  ADDR_W  DUT store address.
REQ-017 write_data  in  DATA_W  DUT store data.
REQ-018 core_reset  out  1  active-high reset driven to the DUT.
REQ-019 done  out  1  test finished (PASS or FAIL).
REQ-020 pass  out  1  valid only while done=1.
REQ-021 timeout  out  1  failure was caused by timeout.
REQ-022 err_cnt  out  8  count of mismatches, saturating at 255.
REQ-023 match_cnt  out  IW+1  count of matched expected stores.
REQ-024 cycle_cnt  out  16  count of RUN cycles, saturating at 0xFFFF.

Function
REQ-025 States are IDLE, RST, RUN, PASS, FAIL, one-hot or binary encoded.
REQ-026 The table is written on cfg_we only in IDLE, PASS or FAIL; cfg_we in RST or RUN is ignored.
REQ-027 IDLE: core_reset=1; start moves to RST, latches exp_count, and clears ptr, err_cnt, match_cnt, cycle_cnt and timeout.
REQ-028 RST: core_reset=1 for exactly RST_CYCLES cycles, then moves to RUN.
REQ-029 RUN: core_reset=0 and cycle_cnt increments every cycle.
REQ-030 In RUN, a store (mem_write=1) with data_adr==exp_addr[ptr] and write_data==exp_data[ptr] increments ptr and match_cnt.
REQ-031 In RUN, a store with data_adr==exp_addr[ptr] but different data increments err_cnt and then depends on mode.
REQ-032 With STOP_ON_ERR=1, that mismatch sends the FSM to FAIL on the next edge.
REQ-033 With STOP_ON_ERR=0, that mismatch advances ptr and the run continues.
REQ-034 Stores to any other address are ignored; only in-order matching is checked.
REQ-035 When ptr equals the latched count, the FSM moves to PASS if err_cnt==0, otherwise to FAIL.
REQ-036 A latched count of 0 gives PASS on the first RUN cycle.
REQ-037 When cycle_cnt reaches TIMEOUT-1 in RUN without completion, the FSM moves to FAIL and sets timeout=1.
REQ-038 If the completing store and the timeout occur on the same cycle, completion wins and timeout stays 0.
REQ-039 PASS/FAIL: done=1, pass=1 only in PASS, core_reset=1 (DUT frozen), and all counters hold.
REQ-040 PASS/FAIL: start begins a new run exactly as from IDLE.
REQ-041 start is ignored in RST and RUN.
REQ-042 Outputs are registered with one-cycle latency from the deciding store to done.

Reset
REQ-043 reset=0 asynchronously forces IDLE, core_reset=1, done=0, pass=0, timeout=0 and all counters 0, including mid-run.
REQ-044 Table contents are not reset.

Verification
REQ-045 Table {0x64:0x19}, count 1, start; DUT stores 0x19 to 0x64 at RUN cycle 17 -> PASS, done=1, pass=1, match_cnt=1, cycle_cnt=18.
REQ-046 Same table; DUT stores 0x07 to 0x64 with STOP_ON_ERR=1 -> next cycle FAIL, err_cnt=1, timeout=0, core_reset=1.
REQ-047 STOP_ON_ERR=0, 3 entries, second mismatched -> FAIL after third store, err_cnt=1, match_cnt=2.
REQ-048 No matching store within 30 cycles -> FAIL, timeout=1, cycle_cnt=29.
REQ-049 reset pulled low mid-RUN at cycle 10 -> immediate IDLE, core_reset=1, counters 0; restart re-runs to PASS with the preserved table.
REQ-050 Count 0 -> PASS one cycle after RST completes; cfg_we during RUN leaves the table unchanged.
